// File: rtl/queue_burst_pkg.sv
// Shared types and defaults for the queue burst reader.
// Optional stall timeout is enabled by defining QUEUE_BURST_READER_TIMEOUT_EN.
package queue_burst_pkg;

  localparam int unsigned DefDataWidth     = 8;
  localparam int unsigned DefMaxLen        = 16;
  localparam int unsigned DefTimeoutCycles = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Skid entry layout at the default width; the skid module builds the same
  // {last, data} layout at its own DATA_WIDTH.
  typedef struct packed {
    logic                    last;
    logic [DefDataWidth-1:0] data;
  } skid_entry_t;

endpackage

// File: rtl/queue_burst_skid.sv
// Two-entry skid FIFO holding popped buffer words and their last tags.
// Entry 0 is always the head; a simultaneous load and pop keeps order.
module queue_burst_skid
  import queue_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last
);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t     ent_q [2];
  entry_t     ent_d [2];
  logic [1:0] occ_q, occ_d;
  logic [1:0] occ_after_pop;

  // Shift on pop, then write the incoming word into the first free slot.
  always_comb begin
    ent_d         = ent_q;
    occ_after_pop = occ_q - 2'(pop);
    if (pop) begin
      ent_d[0] = ent_q[1];
    end
    if (load) begin
      if (occ_after_pop == 2'd0) begin
        ent_d[0] = '{last: load_last, data: load_data};
      end else begin
        ent_d[1] = '{last: load_last, data: load_data};
      end
    end
    occ_d = occ_after_pop + 2'(load);
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      occ_q    <= 2'd0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      occ_q    <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = ent_q[0].data;
  assign head_last = ent_q[0].last;

endmodule

// File: rtl/queue_burst_reader.sv
// Burst reader: pops N words from the queue buffer and streams them out with
// out_last on the final word. A 2-entry skid absorbs the 1-cycle read latency.
// Define QUEUE_BURST_READER_TIMEOUT_EN to add the stall timeout and err_timeout.
module queue_burst_reader
  import queue_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned MAX_LEN        = DefMaxLen,
`ifdef QUEUE_BURST_READER_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
`endif
  localparam int unsigned LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [LEN_W-1:0]      req_len,
  output logic                  req_ready,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  burst_done,
  output logic                  busy
`ifdef QUEUE_BURST_READER_TIMEOUT_EN
  ,
  output logic                  err_timeout
`endif
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic             inflight_q;
  logic             rd_last_q, rd_last_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] clamped_len;
  logic [1:0]       occ;
  logic             head_last;
  logic             pop;
  logic [2:0]       pending;

`ifdef QUEUE_BURST_READER_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
  logic [StallW-1:0] stall_q, stall_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
`endif

  assign clamped_len = (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;
  assign pop         = out_valid & out_ready;
  // Words that will sit in the skid after this edge if no further read issues.
  assign pending     = 3'(occ) + 3'(inflight_q) - 3'(pop);

  // Next-state, read issue and handshake decisions.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;
    req_ready  = 1'b0;
    fifo_rd_en = 1'b0;
`ifdef QUEUE_BURST_READER_TIMEOUT_EN
    stall_d    = stall_q;
    abort_d    = abort_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          len_d    = clamped_len;
          issued_d = '0;
`ifdef QUEUE_BURST_READER_TIMEOUT_EN
          stall_d  = '0;
          abort_d  = 1'b0;
          err_d    = 1'b0;
`endif
          if (clamped_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        fifo_rd_en = !fifo_rd_empty && (issued_q < len_q) && (pending < 3'd2);
        if (fifo_rd_en) begin
          issued_d  = issued_q + LEN_W'(1);
          rd_last_d = (issued_d == len_q);
          if (issued_d == len_q) begin
            state_d = StDrain;
          end
        end
`ifdef QUEUE_BURST_READER_TIMEOUT_EN
        if (fifo_rd_en) begin
          stall_d = '0;
        end else if (fifo_rd_empty && (issued_q < len_q)) begin
          stall_d = stall_q + StallW'(1);
          if (stall_d == StallW'(TIMEOUT_CYCLES)) begin
            // Abandon the rest; words already held still drain untagged.
            stall_d = '0;
            abort_d = 1'b1;
            err_d   = 1'b1;
            state_d = StDrain;
          end
        end
`endif
      end
      StDrain: begin
        if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
`ifdef QUEUE_BURST_READER_TIMEOUT_EN
        if (abort_q && !out_valid && !inflight_q) begin
          done_d  = 1'b1;
          abort_d = 1'b0;
          state_d = StIdle;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= fifo_rd_en;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end

`ifdef QUEUE_BURST_READER_TIMEOUT_EN
  // Stall counter, abort flag and sticky timeout error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;
`endif

  queue_burst_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (inflight_q),
    .load_data (fifo_rd_data),
    .load_last (rd_last_q),
    .pop       (pop),
    .occ       (occ),
    .head_data (out_data),
    .head_last (head_last)
  );

  assign out_valid  = (occ != 2'd0);
  assign out_last   = out_valid & head_last;
  assign burst_done = done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_queue_burst_reader.sv
// Randomised bench for queue_burst_reader: a behavioural queue buffer feeds the
// DUT and a scoreboard predicts each burst as the next min(len, MAX_LEN) words.
module tb_queue_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned ML = 16;
  localparam int unsigned LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [LW-1:0] req_len = '0;
  logic          req_ready;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic          burst_done;
  logic          busy;

  always #5 clk = ~clk;

  queue_burst_reader #(
    .DATA_WIDTH (DW),
    .MAX_LEN    (ML)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_len       (req_len),
    .req_ready     (req_ready),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .burst_done    (burst_done),
    .busy          (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural queue buffer.
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            rd_on_empty = 0;
  logic [DW-1:0] feed_q [$];
  int            feed_gap = 0;
  int            feed_cnt = 0;

  // Reference model: every word ever written, in order, not yet claimed.
  logic [DW-1:0] src_q [$];
  logic [DW:0]   exp_burst [$];
  logic [DW:0]   exp_w;

  int   hs_total = 0, lost_words = 0, max_outst = 0, outst = 0;
  int   burst_hs = 0, first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  int   acc_cyc = 0, rd_at_start = 0;
  int   ready_mode = 0, pat = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  assign fifo_rd_empty = (wr_ptr == rd_ptr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Buffer read port: registered data one cycle after the pop strobe.
  always @(posedge clk) begin
    if (rst_n && fifo_rd_en) begin
      if (wr_ptr == rd_ptr) begin
        rd_on_empty <= rd_on_empty + 1;
      end else begin
        fifo_rd_data <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1;
      end
    end
  end

  // Trickle writer for words scheduled with push_later.
  always @(posedge clk) begin
    #2;
    if (feed_q.size() != 0) begin
      if (feed_cnt >= feed_gap) begin
        mem[wr_ptr] = feed_q.pop_front();
        wr_ptr++;
        feed_cnt = 0;
      end else begin
        feed_cnt++;
      end
    end
  end

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      2: begin
        out_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
        pat++;
      end
      default: out_ready = 1'b0;
    endcase
  end

  // Stream monitor and scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      outst = rd_ptr + ((fifo_rd_en && !fifo_rd_empty) ? 1 : 0) - hs_total - lost_words
              - ((out_valid && out_ready) ? 1 : 0);
      if (outst > max_outst) max_outst = outst;
      if (prev_stall) begin
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_data", 32'(out_data), 32'(prev_data));
        check_eq("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        check_eq("word_expected", 32'(exp_burst.size() != 0), 32'd1);
        if (exp_burst.size() != 0) begin
          exp_w = exp_burst.pop_front();
          check_eq("out_data", 32'(out_data), 32'(exp_w[DW-1:0]));
          check_eq("out_last", 32'(out_last), 32'(exp_w[DW]));
        end
        if (burst_hs == 0) first_hs_cyc = cyc;
        burst_hs++;
        last_hs_cyc = cyc;
        hs_total++;
      end
      if (burst_done) done_cyc = cyc;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_now(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
    src_q.push_back(w);
  endtask

  task automatic push_later(input logic [DW-1:0] w);
    feed_q.push_back(w);
    src_q.push_back(w);
  endtask

  task automatic start_burst(input int len);
    int n;
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    n = (len > int'(ML)) ? int'(ML) : len;
    for (int i = 0; i < n; i++) begin
      w = src_q.pop_front();
      exp_burst.push_back({(i == n - 1), w});
    end
    burst_hs    = 0;
    rd_at_start = rd_ptr;
    req_valid   = 1'b1;
    req_len     = LW'(len);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(input int len, input bit chk_busy);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      #1;
      if (burst_done) begin
        got = 1'b1;
      end else begin
        check_eq("req_ready_busy", 32'(req_ready), 32'd0);
        if (chk_busy) check_eq("busy_hold", 32'(busy), 32'd1);
      end
    end
    check_eq("burst_done_seen", 32'(got), 32'd1);
    if (got) begin
      check_eq("done_timing", 32'(done_cyc), 32'((len == 0) ? acc_cyc : last_hs_cyc + 1));
      check_eq("burst_words_left", 32'(exp_burst.size()), 32'd0);
      @(negedge clk);
      #1;
      check_eq("done_one_cycle", 32'(burst_done), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len, n, k;
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_burst_done", 32'(burst_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back burst of four preloaded words.
    ready_mode = 0;
    for (int i = 0; i < 4; i++) push_now(8'h10 + 8'(i));
    start_burst(4);
    wait_done(4, 1'b1);
    check_eq("first_word_latency", 32'(first_hs_cyc), 32'(acc_cyc + 2));
    check_eq("four_consecutive", 32'(last_hs_cyc - first_hs_cyc), 32'd3);

    // Zero-length request.
    start_burst(0);
    wait_done(0, 1'b0);
    check_eq("len0_no_read", 32'(rd_ptr - rd_at_start), 32'd0);

    // Backpressure pattern 1,0,0,1 on a 6-word burst from 8 words.
    ready_mode = 2;
    pat = 0;
    for (int i = 0; i < 8; i++) push_now(8'h20 + 8'(i));
    start_burst(6);
    wait_done(6, 1'b1);
    check_eq("bp_words_left", 32'(wr_ptr - rd_ptr), 32'd2);
    check_eq("bp_outstanding_le2", 32'(max_outst <= 2), 32'd1);
    ready_mode = 0;
    start_burst(2);
    wait_done(2, 1'b1);

    // Empty buffer; words trickle in five cycles apart.
    feed_gap = 4;
    feed_cnt = 0;
    push_later(8'hA1);
    push_later(8'hA2);
    push_later(8'hA3);
    start_burst(3);
    wait_done(3, 1'b1);

    // Over-long request is clamped to MAX_LEN.
    ready_mode = 1;
    for (int i = 0; i < 20; i++) push_now(8'h60 + 8'(i));
    start_burst(20);
    wait_done(20, 1'b1);
    check_eq("clamp_burst_words", 32'(burst_hs), 32'd16);
    check_eq("clamp_words_left", 32'(wr_ptr - rd_ptr), 32'd4);
    start_burst(4);
    wait_done(4, 1'b1);

    // Reset in FETCH after two reads have been issued.
    ready_mode = 3;
    for (int i = 0; i < 4; i++) push_now(8'h50 + 8'(i));
    start_burst(4);
    for (int i = 0; i < 20 && (rd_ptr - rd_at_start) < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("reads_before_reset", 32'(rd_ptr - rd_at_start), 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_burst.delete();
    lost_words = rd_ptr - hs_total;
    @(negedge clk);
    check_eq("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_out_last", 32'(out_last), 32'd0);
    check_eq("mid_rst_out_data", 32'(out_data), 32'd0);
    check_eq("mid_rst_burst_done", 32'(burst_done), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_words_left", 32'(wr_ptr - rd_ptr), 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_q.delete();
    src_q.push_back(8'h52);
    src_q.push_back(8'h53);
    ready_mode = 0;
    start_burst(2);
    wait_done(2, 1'b1);

    // Randomised bursts with mixed preload, trickle and backpressure.
    for (int it = 0; it < 12; it++) begin
      len        = $urandom_range(1, 20);
      n          = (len > int'(ML)) ? int'(ML) : len;
      k          = $urandom_range(0, n);
      ready_mode = $urandom_range(0, 2);
      feed_gap   = $urandom_range(0, 3);
      feed_cnt   = 0;
      for (int j = 0; j < k; j++) push_now(8'($urandom));
      for (int j = 0; j < n - k + int'($urandom_range(0, 2)); j++) push_later(8'($urandom));
      start_burst(len);
      wait_done(len, 1'b1);
      for (int j = 0; j < 200 && feed_q.size() != 0; j++) @(posedge clk);
    end

    check_eq("max_outstanding_le2", 32'(max_outst <= 2), 32'd1);
    check_eq("no_read_on_empty", 32'(rd_on_empty), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
